ip_fetch_sequencer: RTL and testbench



---
 rtl/dpc_opcode_pkg.sv | 29 ++
 rtl/delay_timer.sv | 34 +++
 rtl/ip_fetch_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_ip_fetch_sequencer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpc_opcode_pkg.sv
// Shared opcode constants and sequencer state/mode types for the fetch path.
package dpc_opcode_pkg;

    localparam int OPC_W = 16;

    // One-hot decoder outputs that the sequencer has to recognise.
    localparam logic [OPC_W-1:0] OPC_LOOP_BEGIN = 16'h0080;  // Insn 7 '['
    localparam logic [OPC_W-1:0] OPC_LOOP_END   = 16'h0100;  // Insn 8 ']'
    localparam logic [OPC_W-1:0] OPC_HALT       = 16'h8000;  // Insn F

    typedef enum logic [3:0] {
        S_INIT,
        S_IDLE,
        S_DIR,
        S_STEP,
        S_WAIT_S,
        S_LOAD,
        S_WAIT_L,
        S_CHECK,
        S_ERROR
    } seq_state_e;

    typedef enum logic [1:0] {
        MODE_PLAIN,
        MODE_FWD,
        MODE_BACK
    } seq_mode_e;

endpackage

// File: rtl/delay_timer.sv
// Loadable down-counter; done_o is high while the count sits at zero.
// Loading N-1 on entry to a wait state keeps that state for exactly N cycles.
module delay_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: load wins, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = value_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/ip_fetch_sequencer.sv
// Instruction-fetch sequencer: drives the IP counter and ROM strobes with
// settle delays, latches the decoded opcode and autonomously runs
// bracket-matching scans in either direction.
// STEP_WAIT and LOAD_WAIT must both be at least 1.
module ip_fetch_sequencer
    import dpc_opcode_pkg::*;
#(
    parameter int STEP_WAIT = 2,
    parameter int LOAD_WAIT = 1,
    parameter int DEPTH_W   = 8
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic        Skip,
    input  logic        Back,
    input  logic [15:0] OpcodeIn,
    output logic        IpCount,
    output logic        IpReverse,
    output logic        RomLoad,
    output logic [15:0] Opcode,
    output logic        Valid,
    output logic        Busy,
    output logic        SeqErr
);

    localparam int TW = 8;

    seq_state_e         state_q, state_d;
    seq_mode_e          mode_q, mode_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [OPC_W-1:0]   opc_q, opc_d;
    logic               boot_q, boot_d;
    logic               rev_q, rev_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               ic_q, ic_d;
    logic               rl_q, rl_d;
    logic               busy_q, busy_d;

    logic               tmr_load, tmr_done;
    logic [TW-1:0]      tmr_val;
    logic [OPC_W-1:0]   open_op, close_op;

    // One shared timer: WAIT_S and WAIT_L are never active together.
    assign tmr_load = (state_q == S_STEP) || (state_q == S_LOAD) ||
                      (state_q == S_INIT && !boot_q);
    assign tmr_val  = (state_q == S_STEP) ? TW'(STEP_WAIT - 1) : TW'(LOAD_WAIT - 1);

    delay_timer #(.W(TW)) u_timer (
        .clk_i   (Clk),
        .rst_ni  (Rst_n),
        .load_i  (tmr_load),
        .value_i (tmr_val),
        .done_o  (tmr_done)
    );

    // Next-state, scan bookkeeping and next values of the registered outputs.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        depth_d  = depth_q;
        opc_d    = opc_q;
        boot_d   = boot_q;
        rev_d    = rev_q;
        valid_d  = valid_q;
        err_d    = err_q;
        // A back-scan hunts for '[' and nests on ']'; forward is the mirror.
        open_op  = (mode_q == MODE_BACK) ? OPC_LOOP_END   : OPC_LOOP_BEGIN;
        close_op = (mode_q == MODE_BACK) ? OPC_LOOP_BEGIN : OPC_LOOP_END;

        case (state_q)
            // First cycle after reset is the address-0 load; boot_q marks it.
            S_INIT: begin
                if (boot_q) boot_d  = 1'b0;
                else        state_d = S_WAIT_L;
            end
            S_IDLE: begin
                if (Start) begin
                    valid_d = 1'b0;
                    if (Skip && Back) begin
                        state_d = S_ERROR;
                    end else begin
                        mode_d  = Back ? MODE_BACK : (Skip ? MODE_FWD : MODE_PLAIN);
                        depth_d = '0;
                        // Direction flips only on entry to DIR, so the counter
                        // sees a settled IpReverse before the step strobe.
                        if (Back != rev_q) begin
                            rev_d   = Back;
                            state_d = S_DIR;
                        end else begin
                            state_d = S_STEP;
                        end
                    end
                end
            end
            S_DIR:    state_d = S_STEP;
            S_STEP:   state_d = S_WAIT_S;
            S_WAIT_S: if (tmr_done) state_d = S_LOAD;
            S_LOAD:   state_d = S_WAIT_L;
            S_WAIT_L: if (tmr_done) state_d = S_CHECK;
            S_CHECK: begin
                opc_d = OpcodeIn;
                if (mode_q == MODE_PLAIN) begin
                    state_d = S_IDLE;
                    valid_d = 1'b1;
                end else if (OpcodeIn == OPC_HALT) begin
                    state_d = S_ERROR;
                end else if (OpcodeIn == open_op) begin
                    if (depth_q == '1) begin
                        state_d = S_ERROR;
                    end else begin
                        depth_d = depth_q + DEPTH_W'(1);
                        state_d = S_STEP;
                    end
                end else if (OpcodeIn == close_op) begin
                    if (depth_q == '0) begin
                        state_d = S_IDLE;
                        valid_d = 1'b1;
                    end else begin
                        depth_d = depth_q - DEPTH_W'(1);
                        state_d = S_STEP;
                    end
                end else begin
                    state_d = S_STEP;
                end
            end
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_ERROR;
        endcase

        if (state_d == S_ERROR) begin
            err_d   = 1'b1;
            valid_d = 1'b0;
            depth_d = '0;
        end
        if (state_d == S_IDLE)
            depth_d = '0;

        ic_d   = (state_d == S_STEP);
        rl_d   = (state_d == S_LOAD) || (state_q == S_INIT && boot_q);
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any sequence in flight.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= S_INIT;
            mode_q  <= MODE_PLAIN;
            depth_q <= '0;
            opc_q   <= '0;
            boot_q  <= 1'b1;
            rev_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ic_q    <= 1'b0;
            rl_q    <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            depth_q <= depth_d;
            opc_q   <= opc_d;
            boot_q  <= boot_d;
            rev_q   <= rev_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            ic_q    <= ic_d;
            rl_q    <= rl_d;
            busy_q  <= busy_d;
        end
    end

    assign IpCount   = ic_q;
    assign IpReverse = rev_q;
    assign RomLoad   = rl_q;
    assign Opcode    = opc_q;
    assign Valid     = valid_q;
    assign Busy      = busy_q;
    assign SeqErr    = err_q;

endmodule

// File: tb/tb_ip_fetch_sequencer.sv
// Bench for ip_fetch_sequencer: models the IP counter and ROM, predicts each
// fetch or scan from a program array walk, and watches strobe legality.
module tb_ip_fetch_sequencer;
    import dpc_opcode_pkg::*;

    localparam int AW = 9;
    localparam int ROM_N = 512;
    localparam int DEPTH_MAX = 255;
    localparam logic [15:0] F_RIGHT = 16'h0001, F_PLUS = 16'h0004,
                            F_MINUS = 16'h0008, F_DOT = 16'h0020;

    logic Clk = 1'b0, Rst_n = 1'b0, Start = 1'b0, Skip = 1'b0, Back = 1'b0;
    logic [15:0] opc_in = 16'h0;
    logic IpCount, IpReverse, RomLoad, Valid, Busy, SeqErr;
    logic [15:0] Opcode;

    always #5 Clk = ~Clk;

    ip_fetch_sequencer dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Skip(Skip), .Back(Back),
        .OpcodeIn(opc_in), .IpCount(IpCount), .IpReverse(IpReverse),
        .RomLoad(RomLoad), .Opcode(Opcode), .Valid(Valid), .Busy(Busy),
        .SeqErr(SeqErr)
    );

    logic [15:0] rom [0:ROM_N-1];
    logic [AW-1:0] ip_m = '0;
    int cnt_step = 0, cnt_load = 0, viol = 0;
    logic prev_ic = 1'b0, prev_rl = 1'b0, prev_rev = 1'b0;
    int checks = 0, failures = 0;
    int ref_ip = 0;
    bit rev_ref = 1'b0;

    // Environment: IP counter, ROM register, strobe counters and legality monitor.
    always @(posedge Clk) begin
        if (IpCount) cnt_step <= cnt_step + 1;
        if (RomLoad) cnt_load <= cnt_load + 1;
        if ((IpCount && RomLoad) || (IpCount && prev_ic) || (RomLoad && prev_rl) ||
            ((IpReverse !== prev_rev) && (IpCount || prev_ic)))
            viol <= viol + 1;
        prev_ic  <= IpCount;
        prev_rl  <= RomLoad;
        prev_rev <= IpReverse;
        if (!Rst_n) begin
            ip_m <= '0;
        end else begin
            if (IpCount) ip_m <= IpReverse ? ip_m - 1'b1 : ip_m + 1'b1;
            if (RomLoad) opc_in <= rom[ip_m];
        end
    end

    // Walk the program like the spec's scan rules; steps include the final one.
    function automatic void ref_scan(input int start, input bit back,
                                     output int steps, output int stop, output bit err);
        int p, d;
        logic [15:0] op, op_open, op_close;
        p = start; d = 0; steps = 0; stop = start; err = 1'b0;
        op_open  = back ? OPC_LOOP_END : OPC_LOOP_BEGIN;
        op_close = back ? OPC_LOOP_BEGIN : OPC_LOOP_END;
        for (int k = 0; k < 2000; k++) begin
            p = (p + (back ? ROM_N - 1 : 1)) % ROM_N;
            steps++;
            op = rom[p];
            stop = p;
            if (op == OPC_HALT) begin err = 1'b1; return; end
            if (op == op_open) begin
                if (d == DEPTH_MAX) begin err = 1'b1; return; end
                d++;
            end else if (op == op_close) begin
                if (d == 0) return;
                d--;
            end
        end
        err = 1'b1;
    endfunction

    task automatic fill_halt();
        for (int i = 0; i < ROM_N; i++) rom[i] = OPC_HALT;
    endtask

    task automatic load_prog1();
        fill_halt();
        rom[0] = OPC_LOOP_BEGIN; rom[1] = F_PLUS;  rom[2] = OPC_LOOP_BEGIN;
        rom[3] = F_MINUS;        rom[4] = OPC_LOOP_END; rom[5] = F_RIGHT;
        rom[6] = OPC_LOOP_END;   rom[7] = F_DOT;
    endtask

    task automatic gen_program();
        int d, b;
        logic [15:0] one;
        one = 16'h0001;
        fill_halt();
        d = 0;
        for (int i = 0; i < 200; i++) begin
            b = int'($urandom_range(0, 5));
            if (b == 0 && d < 6) begin rom[i] = OPC_LOOP_BEGIN; d++; end
            else if (b == 1 && d > 0) begin rom[i] = OPC_LOOP_END; d--; end
            else begin
                b = int'($urandom_range(0, 12));
                rom[i] = one << ((b < 7) ? b : b + 2);
            end
        end
        for (int i = 200; i < 210; i++)
            if (d > 0) begin rom[i] = OPC_LOOP_END; d--; end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (Busy !== 1'b0 && n < 5000) begin @(negedge Clk); n++; end
        checks++;
        if (Busy !== 1'b0) begin
            failures++; $display("FAIL idle_timeout: Busy=%b required 0", Busy);
        end
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        Rst_n = 1'b0; Start = 1'b0; Skip = 1'b0; Back = 1'b0;
        @(negedge Clk);
        checks++;
        if ({IpCount, IpReverse, RomLoad, Opcode, Valid, SeqErr, Busy} !==
            {3'b000, 16'h0000, 3'b001}) begin
            failures++;
            $display("FAIL reset_values: ic=%b rev=%b rl=%b opc=%h v=%b err=%b busy=%b required 0 0 0 0000 0 0 1",
                     IpCount, IpReverse, RomLoad, Opcode, Valid, SeqErr, Busy);
        end
        Rst_n = 1'b1; ref_ip = 0; rev_ref = 1'b0;
    endtask

    task automatic wait_boot();
        int s0, l0, n;
        s0 = cnt_step; l0 = cnt_load; n = 0;
        while (!(Valid === 1'b1 && Busy === 1'b0) && n < 50) begin @(negedge Clk); n++; end
        checks++;
        if (Valid !== 1'b1 || Busy !== 1'b0) begin
            failures++; $display("FAIL boot_valid: Valid=%b Busy=%b required 1 0", Valid, Busy);
        end
        checks++;
        if (cnt_load - l0 != 1 || cnt_step - s0 != 0) begin
            failures++;
            $display("FAIL boot_strobes: loads=%0d steps=%0d required 1 0", cnt_load - l0, cnt_step - s0);
        end
        checks++;
        if (Opcode !== rom[0]) begin
            failures++; $display("FAIL boot_opcode: got %h required %h", Opcode, rom[0]);
        end
    endtask

    task automatic check_quiet(input string name);
        int s0, l0;
        s0 = cnt_step; l0 = cnt_load;
        repeat (20) @(negedge Clk);
        checks++;
        if (cnt_step != s0 || cnt_load != l0 || SeqErr !== 1'b1 || Busy !== 1'b1 || Valid !== 1'b0) begin
            failures++;
            $display("FAIL %s: steps+%0d loads+%0d err=%b busy=%b valid=%b required 0 0 1 1 0",
                     name, cnt_step - s0, cnt_load - l0, SeqErr, Busy, Valid);
        end
    endtask

    // mode: 0 plain, 1 forward scan, 2 back scan.
    task automatic run_op(input int mode, input bit inject, output int obs_steps, output bit got_err);
        int exp_steps, exp_ip, s0, l0, lat;
        bit exp_err, need_dir;
        exp_err = 1'b0; exp_steps = 1;
        need_dir = ((mode == 2) != rev_ref);
        if (mode == 0) exp_ip = (ref_ip + 1) % ROM_N;
        else ref_scan(ref_ip, mode == 2, exp_steps, exp_ip, exp_err);

        wait_idle();
        s0 = cnt_step; l0 = cnt_load;
        @(negedge Clk);
        Start = 1'b1; Skip = (mode == 1); Back = (mode == 2);
        @(negedge Clk);
        Start = 1'b0; Skip = 1'b0; Back = 1'b0;
        checks++;
        if (Valid !== 1'b0 || Busy !== 1'b1) begin
            failures++; $display("FAIL accept: Valid=%b Busy=%b required 0 1", Valid, Busy);
        end
        checks++;
        if (IpCount !== !need_dir || IpReverse !== (mode == 2)) begin
            failures++;
            $display("FAIL dir_phase: IpCount=%b IpReverse=%b required %b %b",
                     IpCount, IpReverse, !need_dir, mode == 2);
        end
        lat = 0;
        while (Valid !== 1'b1 && SeqErr !== 1'b1 && lat < 4000) begin
            Start = inject && (lat == 2);
            Skip  = Start & 1'($urandom_range(0, 1));
            Back  = Start & 1'($urandom_range(0, 1));
            @(negedge Clk);
            lat++;
        end
        Start = 1'b0; Skip = 1'b0; Back = 1'b0;
        obs_steps = cnt_step - s0;
        got_err = exp_err;

        checks++;
        if (obs_steps != exp_steps) begin
            failures++; $display("FAIL steps(mode %0d): got %0d required %0d", mode, obs_steps, exp_steps);
        end
        if (exp_err) begin
            checks++;
            if (SeqErr !== 1'b1 || Busy !== 1'b1 || Valid !== 1'b0) begin
                failures++;
                $display("FAIL err_flags: err=%b busy=%b valid=%b required 1 1 0", SeqErr, Busy, Valid);
            end
        end else begin
            checks++;
            if (Valid !== 1'b1 || Busy !== 1'b0 || SeqErr !== 1'b0) begin
                failures++;
                $display("FAIL done_flags: valid=%b busy=%b err=%b required 1 0 0", Valid, Busy, SeqErr);
            end
            checks++;
            if (cnt_load - l0 != exp_steps) begin
                failures++; $display("FAIL loads: got %0d required %0d", cnt_load - l0, exp_steps);
            end
            checks++;
            if (int'(ip_m) != exp_ip || Opcode !== rom[exp_ip]) begin
                failures++;
                $display("FAIL landing: ip=%0d opc=%h required %0d %h", ip_m, Opcode, exp_ip, rom[exp_ip]);
            end
            if (mode == 0) begin
                checks++;
                if (lat != 6 + int'(need_dir)) begin
                    failures++; $display("FAIL latency: got %0d required %0d", lat, 6 + int'(need_dir));
                end
            end
        end
        ref_ip = exp_ip;
        rev_ref = (mode == 2);
    endtask

    task automatic test_reset();
        load_prog1();
        apply_reset();
    endtask

    task automatic test_boot();
        wait_boot();
    endtask

    task automatic test_fwd_scan();
        int st; bit e;
        run_op(1, 1'b0, st, e);
        checks++;
        if (st != 6 || Opcode !== OPC_LOOP_END) begin
            failures++; $display("FAIL fwd_prog1: steps=%0d opc=%h required 6 %h", st, Opcode, OPC_LOOP_END);
        end
    endtask

    task automatic test_back_scan();
        int st; bit e;
        run_op(2, 1'b0, st, e);
        checks++;
        if (st != 6 || Opcode !== OPC_LOOP_BEGIN) begin
            failures++; $display("FAIL back_prog1: steps=%0d opc=%h required 6 %h", st, Opcode, OPC_LOOP_BEGIN);
        end
    endtask

    task automatic test_plain();
        int st; bit e;
        run_op(0, 1'b0, st, e);    // follows a back-scan, so DIR is inserted
        run_op(0, 1'b1, st, e);
        repeat (5) @(negedge Clk);
        checks++;
        if (Valid !== 1'b1 || Opcode !== rom[ref_ip]) begin
            failures++; $display("FAIL hold: valid=%b opc=%h required 1 %h", Valid, Opcode, rom[ref_ip]);
        end
    endtask

    task automatic test_back_to_back();
        int st; bit e;
        for (int i = 0; i < 3; i++) run_op(0, 1'b0, st, e);
    endtask

    task automatic test_halt_error();
        int st; bit e;
        fill_halt();
        rom[0] = OPC_LOOP_BEGIN; rom[1] = F_PLUS;
        apply_reset();
        wait_boot();
        run_op(1, 1'b0, st, e);
        checks++;
        if (st != 2 || SeqErr !== 1'b1) begin
            failures++; $display("FAIL halt_scan: steps=%0d err=%b required 2 1", st, SeqErr);
        end
        check_quiet("halt_quiet");
        apply_reset();
        wait_boot();
    endtask

    task automatic test_both_flags();
        wait_idle();
        @(negedge Clk);
        Start = 1'b1; Skip = 1'b1; Back = 1'b1;
        @(negedge Clk);
        Start = 1'b0; Skip = 1'b0; Back = 1'b0;
        checks++;
        if (SeqErr !== 1'b1 || Busy !== 1'b1 || Valid !== 1'b0 || IpCount !== 1'b0) begin
            failures++;
            $display("FAIL both_flags: err=%b busy=%b valid=%b ic=%b required 1 1 0 0",
                     SeqErr, Busy, Valid, IpCount);
        end
        check_quiet("both_quiet");
        apply_reset();
        wait_boot();
    endtask

    task automatic test_overflow();
        int st; bit e;
        fill_halt();
        for (int i = 0; i <= DEPTH_MAX + 1; i++) rom[i] = OPC_LOOP_BEGIN;
        apply_reset();
        wait_boot();
        run_op(1, 1'b0, st, e);
        checks++;
        if (st != DEPTH_MAX + 1 || SeqErr !== 1'b1) begin
            failures++; $display("FAIL overflow: steps=%0d err=%b required %0d 1", st, SeqErr, DEPTH_MAX + 1);
        end
        apply_reset();
        wait_boot();
    endtask

    task automatic test_reset_mid();
        int s0, l0;
        load_prog1();
        apply_reset();
        wait_boot();
        wait_idle();
        s0 = cnt_step; l0 = cnt_load;
        @(negedge Clk); Start = 1'b1;
        @(negedge Clk); Start = 1'b0;      // in STEP
        @(negedge Clk); Rst_n = 1'b0;      // in WAIT_S
        @(negedge Clk);
        checks++;
        if (cnt_load != l0 || cnt_step != s0 + 1 || RomLoad !== 1'b0 || Busy !== 1'b1 || Valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: loads+%0d steps+%0d rl=%b busy=%b valid=%b required 0 1 0 1 0",
                     cnt_load - l0, cnt_step - s0, RomLoad, Busy, Valid);
        end
        Rst_n = 1'b1; ref_ip = 0; rev_ref = 1'b0;
        wait_boot();
    endtask

    task automatic test_random();
        int st, mode; bit e, inj;
        gen_program();
        apply_reset();
        wait_boot();
        for (int i = 0; i < 40; i++) begin
            mode = int'($urandom_range(0, 2));
            inj  = 1'($urandom_range(0, 1));
            run_op(mode, inj, st, e);
            if (e) begin apply_reset(); wait_boot(); end
        end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_fwd_scan();
        test_back_scan();
        test_plain();
        test_back_to_back();
        test_halt_error();
        test_both_flags();
        test_overflow();
        test_reset_mid();
        test_random();
        checks++;
        if (viol != 0) begin
            failures++; $display("FAIL strobe_rules: violations=%0d required 0", viol);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
